// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write-side bus bundle between the CPU decode and the UART transmit FIFO
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 2
);
  logic             wr;
  logic [7:0]       wdata;
  logic             full;
  logic             overrun;
  logic [FIFO_AW:0] count;

  modport master (
    output wr,
    output wdata,
    input  full,
    input  overrun,
    input  count
  );

  modport slave (
    input  wr,
    input  wdata,
    output full,
    output overrun,
    output count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 serial transmitter fed by a small byte FIFO with runtime baud divider
module uart_tx_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cfg_divider,
  uart_tx_fifo_if.slave        wbus,
  output logic                 busy,
  output logic                 ser_tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nx;
  logic               full_q;
  logic               overrun_q;

  logic [31:0]        div_eff;
  logic [31:0]        div_q;
  logic [31:0]        timer;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic               ser_q;

  logic               push;
  logic               pop;
  logic               tick;
  logic               bit_adv;

  // A divider below 2 would leave no room for the timer reload, so clamp it.
  assign div_eff = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;
  assign push    = wbus.wr & ~full_q;
  assign tick    = (timer == 32'd0);

  assign wbus.full    = full_q;
  assign wbus.overrun = overrun_q;
  assign wbus.count   = count;
  assign busy         = (state != S_IDLE) | (count != '0);
  assign ser_tx       = ser_q;

  // State register for the frame sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the STOP exit pops the next byte directly so frames run back to back.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    bit_adv  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          bit_adv = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Occupancy follows push/pop; a same-cycle push and pop leaves it unchanged.
  always_comb begin
    count_nx = count;
    if (push && !pop) begin
      count_nx = count + CNT_ONE;
    end else if (!push && pop) begin
      count_nx = count - CNT_ONE;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wbus.wdata;
    end
  end

  // FIFO pointers, occupancy, registered full flag and the dropped-write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count     <= count_nx;
      full_q    <= (count_nx == DEPTH_CNT);
      overrun_q <= wbus.wr & full_q;
    end
  end

  // Bit timer and divider latch; the divider is captured only when a byte is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 32'd2;
      timer <= 32'd0;
    end else if (pop) begin
      div_q <= div_eff;
      timer <= div_eff - 32'd1;
    end else if (state != S_IDLE) begin
      if (tick) begin
        timer <= div_q - 32'd1;
      end else begin
        timer <= timer - 32'd1;
      end
    end
  end

  // Shift register and bit index; LSB is always the bit currently on the line in DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= 8'd0;
      bit_idx <= 3'd0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      bit_idx <= 3'd0;
    end else if (bit_adv) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Line driver flop: registered from the current state so the pin never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_q <= 1'b1;
    end else begin
      unique case (state)
        S_START: ser_q <= 1'b0;
        S_DATA:  ser_q <= shreg[0];
        default: ser_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for the UART transmit FIFO
module tb_uart_tx_fifo;

  logic        clk;
  logic        reset;
  logic [31:0] cfg_divider;
  logic        busy;
  logic        ser_tx;

  int tests_run;
  int tests_failed;

  uart_tx_fifo_if #(.FIFO_AW(2)) wbus ();

  uart_tx_fifo #(.FIFO_AW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_divider (cfg_divider),
    .wbus        (wbus),
    .busy        (busy),
    .ser_tx      (ser_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level of an 8N1 frame at bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    wbus.wr = 1'b0;
    wbus.wdata = 8'h00;
    cfg_divider = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ser_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_ser_tx got %b want 1", ser_tx); end
    tests_run++;
    if (wbus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", wbus.full); end
    tests_run++;
    if (wbus.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", wbus.overrun); end
    tests_run++;
    if (wbus.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", wbus.count); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ser_tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset ser_tx=%b busy=%b want 1/0", ser_tx, busy);
    end
  endtask

  task automatic test_single_frame();
    logic exp_line, exp_busy;
    cfg_divider = 32'd4;
    wbus.wr = 1'b1;
    wbus.wdata = 8'h55;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || wbus.count !== 3'd1) begin
      tests_failed++; $display("FAIL single_after_write busy=%b count=%0d want 1/1", busy, wbus.count);
    end
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      exp_line = (k == 0) ? 1'b1 : ((k <= 40) ? frame_bit(8'h55, (k - 1) / 4) : 1'b1);
      exp_busy = (k < 40);
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL single_line k=%0d got %b want %b", k, ser_tx, exp_line);
      end
      tests_run++;
      if (busy !== exp_busy) begin
        tests_failed++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, exp_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic exp_line;
    int j;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'hA3;
    cfg_divider = 32'd4;
    for (int i = 0; i < 3; i++) begin
      wbus.wr = 1'b1;
      wbus.wdata = bytes[i];
      @(posedge clk);
      #1;
    end
    wbus.wr = 1'b0;
    tests_run++;
    if (wbus.count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count got %0d want 2", wbus.count); end
    for (int k = 0; k < 130; k++) begin
      @(posedge clk);
      #1;
      j = k + 1;
      exp_line = (j < 120) ? frame_bit(bytes[j / 40], (j % 40) / 4) : 1'b1;
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL b2b_line j=%0d got %b want %b", j, ser_tx, exp_line);
      end
      if (k == 117 || k == 118) begin
        tests_run++;
        if (busy !== (k == 117)) begin
          tests_failed++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, (k == 117));
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [6];
    logic exp_line;
    int j;
    bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32;
    bytes[3] = 8'h43; bytes[4] = 8'h54; bytes[5] = 8'h65;
    cfg_divider = 32'd100;
    for (int i = 0; i < 6; i++) begin
      wbus.wr = 1'b1;
      wbus.wdata = bytes[i];
      @(posedge clk);
      #1;
      tests_run++;
      if (wbus.full !== (i >= 4)) begin
        tests_failed++; $display("FAIL ovr_full i=%0d got %b want %b", i, wbus.full, (i >= 4));
      end
      tests_run++;
      if (wbus.overrun !== (i == 5)) begin
        tests_failed++; $display("FAIL ovr_pulse i=%0d got %b want %b", i, wbus.overrun, (i == 5));
      end
    end
    wbus.wr = 1'b0;
    tests_run++;
    if (wbus.count !== 3'd4) begin tests_failed++; $display("FAIL ovr_count got %0d want 4", wbus.count); end
    for (int k = 0; k < 5050; k++) begin
      @(posedge clk);
      #1;
      j = k + 4;
      if (k == 0) begin
        tests_run++;
        if (wbus.overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_pulse_end got %b want 0", wbus.overrun); end
      end
      if (j < 5000 && (j % 100) == 50) begin
        exp_line = frame_bit(bytes[j / 1000], (j % 1000) / 100);
        tests_run++;
        if (ser_tx !== exp_line) begin
          tests_failed++; $display("FAIL ovr_line j=%0d got %b want %b", j, ser_tx, exp_line);
        end
      end
      if (j == 5050) begin
        tests_run++;
        if (ser_tx !== 1'b1 || busy !== 1'b0 || wbus.count !== 3'd0) begin
          tests_failed++;
          $display("FAIL ovr_drained ser_tx=%b busy=%b count=%0d want 1/0/0", ser_tx, busy, wbus.count);
        end
      end
    end
  endtask

  task automatic test_divider();
    logic exp_line;
    cfg_divider = 32'd1;
    wbus.wr = 1'b1;
    wbus.wdata = 8'h3C;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      exp_line = (k >= 1 && k <= 20) ? frame_bit(8'h3C, (k - 1) / 2) : 1'b1;
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL div2_line k=%0d got %b want %b", k, ser_tx, exp_line);
      end
      tests_run++;
      if (busy !== (k < 20)) begin
        tests_failed++; $display("FAIL div2_busy k=%0d got %b want %b", k, busy, (k < 20));
      end
    end
    cfg_divider = 32'd4;
    wbus.wr = 1'b1;
    wbus.wdata = 8'hA5;
    @(posedge clk);
    #1;
    wbus.wdata = 8'h5A;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    for (int k = 0; k < 125; k++) begin
      @(posedge clk);
      #1;
      if (k < 40) exp_line = frame_bit(8'hA5, k / 4);
      else if (k < 120) exp_line = frame_bit(8'h5A, (k - 40) / 8);
      else exp_line = 1'b1;
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL divchg_line j=%0d got %b want %b", k, ser_tx, exp_line);
      end
      if (k == 10) cfg_divider = 32'd8;
    end
  endtask

  task automatic test_reset_midframe();
    logic exp_line;
    cfg_divider = 32'd4;
    wbus.wr = 1'b1;
    wbus.wdata = 8'h11;
    @(posedge clk);
    #1;
    wbus.wdata = 8'h22;
    @(posedge clk);
    #1;
    wbus.wdata = 8'h33;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    tests_run++;
    if (ser_tx !== 1'b0 || wbus.count !== 3'd2) begin
      tests_failed++; $display("FAIL midframe_pre ser_tx=%b count=%0d want 0/2", ser_tx, wbus.count);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (ser_tx !== 1'b1) begin tests_failed++; $display("FAIL async_ser_tx got %b want 1", ser_tx); end
    tests_run++;
    if (wbus.count !== 3'd0 || busy !== 1'b0 || wbus.full !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_flush count=%0d busy=%b full=%b want 0/0/0", wbus.count, busy, wbus.full);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    wbus.wr = 1'b1;
    wbus.wdata = 8'h41;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      exp_line = (k >= 1 && k <= 40) ? frame_bit(8'h41, (k - 1) / 4) : 1'b1;
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL postreset_line k=%0d got %b want %b", k, ser_tx, exp_line);
      end
      tests_run++;
      if (busy !== (k < 40)) begin
        tests_failed++; $display("FAIL postreset_busy k=%0d got %b want %b", k, busy, (k < 40));
      end
    end
  endtask

  task automatic test_write_at_stop();
    logic exp_line;
    int max_count;
    max_count = 0;
    cfg_divider = 32'd4;
    wbus.wr = 1'b1;
    wbus.wdata = 8'h81;
    @(posedge clk);
    #1;
    wbus.wr = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) exp_line = 1'b1;
      else if (k <= 41) exp_line = frame_bit(8'h81, (k - 2) / 4);
      else if (k == 42) exp_line = 1'b1;
      else if (k <= 82) exp_line = frame_bit(8'h7E, (k - 43) / 4);
      else exp_line = 1'b1;
      tests_run++;
      if (ser_tx !== exp_line) begin
        tests_failed++; $display("FAIL stopwr_line k=%0d got %b want %b", k, ser_tx, exp_line);
      end
      tests_run++;
      if (busy !== (k < 82)) begin
        tests_failed++; $display("FAIL stopwr_busy k=%0d got %b want %b", k, busy, (k < 82));
      end
      if (int'(wbus.count) > max_count) max_count = int'(wbus.count);
      if (k == 40) begin
        wbus.wr = 1'b1;
        wbus.wdata = 8'h7E;
      end
      if (k == 41) wbus.wr = 1'b0;
    end
    tests_run++;
    if (max_count != 1) begin
      tests_failed++; $display("FAIL stopwr_max_count got %0d want 1", max_count);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_divider();
    test_reset_midframe();
    test_write_at_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
